// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier with a start/done handshake.
// Handles signed or unsigned operands and takes WIDTH/2+1 cycles per product.
module booth_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int unsigned AccW  = WIDTH + 4;
  localparam int unsigned MulW  = WIDTH + 2;
  localparam int unsigned NIter = WIDTH / 2 + 1;
  localparam int unsigned CntW  = $clog2(NIter + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [AccW-1:0]   acc_q;
  logic [AccW-1:0]   m_q;
  logic [MulW-1:0]   q_q;
  logic              qm1_q;

  logic              a_sign, b_sign;
  logic [AccW-1:0]   addend;
  logic [AccW-1:0]   sum;
  logic [AccW-1:0]   acc_nx;
  logic [MulW-1:0]   q_nx;
  logic [2*WIDTH-1:0] prod_nx;

  assign a_sign = is_signed & a[WIDTH-1];
  assign b_sign = is_signed & b[WIDTH-1];

  always_comb begin
    addend = '0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m_q << 1;
      3'b100:         addend = -(m_q << 1);
      3'b101, 3'b110: addend = -m_q;
      default:        addend = '0;
    endcase
    sum     = acc_q + addend;
    // Arithmetic shift by two across the accumulator/multiplier pair.
    acc_nx  = {{2{sum[AccW-1]}}, sum[AccW-1:2]};
    q_nx    = {sum[1:0], q_q[MulW-1:2]};
    prod_nx = {acc_nx[WIDTH-3:0], q_nx};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            m_q     <= {{4{a_sign}}, a};
            q_q     <= {{2{b_sign}}, b};
            qm1_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= CntW'(NIter);
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q <= acc_nx;
          q_q   <= q_nx;
          qm1_q <= q_q[1];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            prod_hi <= prod_nx[2*WIDTH-1:WIDTH];
            prod_lo <= prod_nx[WIDTH-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
